// File: rtl/gpr_pkg.sv
// gpr_pkg: shared GPR write-back types and sizes
package gpr_pkg;
  localparam int NR_REG = 16;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int IDX_W = $clog2(NR_REG);
  typedef logic [ADDR_W-1:0] gpr_addr_t;
  typedef logic [DATA_W-1:0] gpr_data_t;
  typedef enum logic {WB_EXU = 1'b0, WB_LSU = 1'b1} wb_src_e;
  // x0 and addresses beyond the file are never tracked by the scoreboard
  function automatic logic tracked(input gpr_addr_t a);
    return a != '0 && int'(a) < NR_REG;
  endfunction
  function automatic logic is_busy(input logic [NR_REG-1:0] busy, input gpr_addr_t a);
    return tracked(a) && busy[a[IDX_W-1:0]];
  endfunction
endpackage

// File: rtl/gpr_rr_arb2.sv
// gpr_rr_arb2: 2-way round-robin arbiter, index 0 = EXU, index 1 = LSU
module gpr_rr_arb2
  import gpr_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  wb_src_e ptr;
  always_comb gnt = (&req) ? (ptr == WB_LSU ? 2'b10 : 2'b01) : req;
  always_ff @(posedge clock)
    if (!reset) ptr <= WB_EXU;
    else if (|gnt) ptr <= gnt[0] ? WB_LSU : WB_EXU;
endmodule

// File: rtl/gpr_wb_ctrl.sv
// gpr_wb_ctrl: GPR write-back arbiter and RAW/WAW issue scoreboard
module gpr_wb_ctrl
  import gpr_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              iss_valid,
  output logic                              iss_ready,
  input  logic [ADDR_W-1:0]                 iss_rd,
  input  logic [ADDR_W-1:0]                 iss_rs1,
  input  logic [ADDR_W-1:0]                 iss_rs2,
  input  logic                              exu_valid,
  output logic                              exu_ready,
  input  logic [ADDR_W-1:0]                 exu_rd,
  input  logic [DATA_W-1:0]                 exu_data,
  input  logic                              lsu_valid,
  output logic                              lsu_ready,
  input  logic [ADDR_W-1:0]                 lsu_rd,
  input  logic [DATA_W-1:0]                 lsu_data,
  output logic                              gpr_wen,
  output logic [ADDR_W-1:0]                 gpr_waddr,
  output logic [DATA_W-1:0]                 gpr_wdata,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic                              err
);
  localparam int IW = $clog2(MAX_INFLIGHT+1);
  logic [NR_REG-1:0] busy, busy_nxt;
  logic [1:0] gnt;
  logic fire, any_gnt, dec;
  gpr_addr_t g_rd;
  gpr_data_t g_data;
  gpr_rr_arb2 u_arb (.clock, .reset, .req({lsu_valid, exu_valid}), .gnt);
  assign exu_ready = gnt[0];
  assign lsu_ready = gnt[1];
  assign any_gnt = |gnt;
  assign g_rd = gnt[1] ? lsu_rd : exu_rd;
  assign g_data = gnt[1] ? lsu_data : exu_data;
  assign iss_ready = !is_busy(busy, iss_rs1) && !is_busy(busy, iss_rs2) &&
                     !is_busy(busy, iss_rd) && inflight < IW'(MAX_INFLIGHT);
  assign fire = iss_valid && iss_ready;
  assign dec = any_gnt && inflight != '0;
  // clear on the GPR update edge; a same-cycle set of the same bit wins
  always_comb begin
    busy_nxt = busy;
    if (gpr_wen && tracked(gpr_waddr)) busy_nxt[gpr_waddr[IDX_W-1:0]] = 1'b0;
    if (fire && tracked(iss_rd)) busy_nxt[iss_rd[IDX_W-1:0]] = 1'b1;
    busy_nxt[0] = 1'b0;
  end
  always_ff @(posedge clock)
    if (!reset) begin
      busy <= '0;
      inflight <= '0;
      gpr_wen <= 1'b0;
      gpr_waddr <= '0;
      gpr_wdata <= '0;
      err <= 1'b0;
    end else begin
      busy <= busy_nxt;
      inflight <= inflight + IW'(fire) - IW'(dec);
      gpr_wen <= any_gnt && g_rd != '0;
      if (any_gnt) begin
        gpr_waddr <= g_rd;
        gpr_wdata <= g_data;
      end
      if (any_gnt && (inflight == '0 || (g_rd != '0 && !is_busy(busy, g_rd)))) err <= 1'b1;
    end
endmodule
